// File: rtl/mem_responder_pkg.sv
// Shared types and default address windows for the memory responder.
// Latency: n/a (types only). Backpressure: n/a.
package mem_responder_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      LOAD  = 3'd2,
      STORE = 3'd3,
      FAULT = 3'd4
   } state_t;

   typedef logic [31:0] word_t;

   localparam logic [15:0] INSTR_BASE_DEF  = 16'h0000;
   localparam logic [15:0] INSTR_LIMIT_DEF = 16'h3FFC;
   localparam logic [15:0] DATA_BASE_DEF   = 16'h4000;
   localparam logic [15:0] DATA_LIMIT_DEF  = 16'hFFFC;

endpackage

// File: rtl/mem_window_check.sv
// Combinational address window check; optional word-alignment check under MEM_RESPONDER_ALIGN_CHECK_EN.
// Latency: 0 cycles. Backpressure: none.
// Without the macro, bits [1:0] do not affect legality beyond the range compare.
module mem_window_check #(
   parameter int unsigned       ADDR_W = 16,
   parameter logic [ADDR_W-1:0] BASE   = '0,
   parameter logic [ADDR_W-1:0] LIMIT  = '1
) (
   input  logic [ADDR_W-1:0] addr,
   output logic              ok
);

   logic [ADDR_W-1:0] offset;
   logic              in_range;

   // Modular offset from BASE: a single compare covers both bounds when LIMIT >= BASE.
   assign offset   = addr - BASE;
   assign in_range = (offset <= (LIMIT - BASE));

`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
   assign ok = in_range && (addr[1:0] == 2'b00);
`else
   assign ok = in_range;
`endif

endmodule

// File: rtl/mem_responder.sv
// Arbitrates fetch and load/store onto one single-port RAM with window checks and sticky segv; align check via MEM_RESPONDER_ALIGN_CHECK_EN.
// Latency: read done MEM_LATENCY+1 cycles after acceptance, store done 1 cycle after acceptance.
// Backpressure: wait_instr/wait_data stay high until the done cycle; FAULT holds both high until reset.
module mem_responder
   import mem_responder_pkg::*;
#(
   parameter int unsigned       ADDR_W      = 16,
   parameter int unsigned       MEM_LATENCY = 2,
   parameter logic [ADDR_W-1:0] INSTR_BASE  = INSTR_BASE_DEF,
   parameter logic [ADDR_W-1:0] INSTR_LIMIT = INSTR_LIMIT_DEF,
   parameter logic [ADDR_W-1:0] DATA_BASE   = DATA_BASE_DEF,
   parameter logic [ADDR_W-1:0] DATA_LIMIT  = DATA_LIMIT_DEF
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              fetch_req,
   input  logic [ADDR_W-1:0] pc,
   input  logic              ld,
   input  logic              st,
   input  logic [ADDR_W-1:0] data_addr,
   input  word_t             store_data,
   output word_t             instruction,
   output word_t             load_data,
   output logic              wait_instr,
   output logic              wait_data,
   output logic              instr_segv,
   output logic              data_segv,
   output logic [ADDR_W-3:0] mem_addr,
   output word_t             mem_wdata,
   output logic              mem_we,
   output logic              mem_re,
   input  word_t             mem_rdata
);

   localparam int unsigned CNT_W = $clog2(MEM_LATENCY + 1);
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LATENCY);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt;
   logic             instr_ok, data_ok;
   logic             data_req, data_bad;
   logic             instr_done, data_done, load_done;
   logic             in_fault;

   mem_window_check #(.ADDR_W(ADDR_W), .BASE(INSTR_BASE), .LIMIT(INSTR_LIMIT)) u_instr_chk (
      .addr (pc),
      .ok   (instr_ok)
   );

   mem_window_check #(.ADDR_W(ADDR_W), .BASE(DATA_BASE), .LIMIT(DATA_LIMIT)) u_data_chk (
      .addr (data_addr),
      .ok   (data_ok)
   );

   assign data_req = ld | st;
   assign data_bad = (ld & st) | ~data_ok;

   always_ff @(posedge clk) begin
      if (!resetn) state <= IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (data_req)       state_nxt = data_bad ? FAULT : (st ? STORE : LOAD);
            else if (fetch_req) state_nxt = instr_ok ? FETCH : FAULT;
         end
         FETCH, LOAD: if (cnt == '0) state_nxt = IDLE;
         STORE:       state_nxt = IDLE;
         FAULT:       state_nxt = FAULT;
         default:     state_nxt = IDLE;
      endcase
   end

   // Done pulses and strobes are masked during reset so an aborted access cannot complete.
   always_comb begin
      instr_done = resetn && (state == FETCH) && (cnt == '0);
      load_done  = resetn && (state == LOAD)  && (cnt == '0);
      data_done  = load_done || (resetn && (state == STORE));
      in_fault   = resetn && (state == FAULT);
      wait_instr = in_fault | (fetch_req & ~instr_done);
      wait_data  = in_fault | (data_req & ~data_done);
      mem_re     = resetn && ((state == FETCH) || (state == LOAD)) && (cnt == CNT_INIT);
      mem_we     = resetn && (state == STORE);
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         cnt         <= '0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
         instruction <= '0;
         load_data   <= '0;
         instr_segv  <= 1'b0;
         data_segv   <= 1'b0;
      end else begin
         if (state == IDLE) begin
            if (data_req) begin
               if (data_bad) begin
                  data_segv <= 1'b1;
               end else begin
                  mem_addr  <= data_addr[ADDR_W-1:2];
                  mem_wdata <= store_data;
                  cnt       <= CNT_INIT;
               end
            end else if (fetch_req) begin
               if (!instr_ok) begin
                  instr_segv <= 1'b1;
               end else begin
                  mem_addr <= pc[ADDR_W-1:2];
                  cnt      <= CNT_INIT;
               end
            end
         end
         if (((state == FETCH) || (state == LOAD)) && (cnt != '0)) cnt <= cnt - 1'b1;
         if (instr_done) instruction <= mem_rdata;
         if (load_done)  load_data   <= mem_rdata;
      end
   end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: cycle table for the main flows plus hand sequences for faults and reset.
// Latency/backpressure: bench drives inputs on negedge and samples 2 time units later.
module tb_mem_responder;

   logic        clk = 1'b0;
   logic        resetn;
   logic        fetch_req, ld, st;
   logic [15:0] pc, data_addr;
   logic [31:0] store_data;
   logic [31:0] instruction, load_data, mem_wdata, mem_rdata;
   logic        wait_instr, wait_data, instr_segv, data_segv, mem_we, mem_re;
   logic [13:0] mem_addr;

   logic [31:0] ram [0:16383];
   logic [31:0] p1, p2;
   logic        bk_we;
   logic [13:0] bk_addr;
   logic [31:0] bk_dat;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   mem_responder dut (
      .clk(clk), .resetn(resetn), .fetch_req(fetch_req), .pc(pc), .ld(ld), .st(st),
      .data_addr(data_addr), .store_data(store_data), .instruction(instruction),
      .load_data(load_data), .wait_instr(wait_instr), .wait_data(wait_data),
      .instr_segv(instr_segv), .data_segv(data_segv), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata)
   );

   // RAM model: two-stage read pipeline gives data two cycles after mem_re.
   always @(posedge clk) begin
      if (bk_we) ram[bk_addr] <= bk_dat;
      else if (mem_we) ram[mem_addr] <= mem_wdata;
      p1 <= mem_re ? ram[mem_addr] : 32'hBAD0BAD0;
      p2 <= p1;
   end
   assign mem_rdata = p2;

   typedef struct {
      logic        fr;
      logic [15:0] pc;
      logic        ld, st;
      logic [15:0] da;
      logic [31:0] sd;
      logic        wi, wd, re, we;
      logic [13:0] addr;
      logic [31:0] ins, ldd;
   } vec_t;

   vec_t vq[$];

   task automatic add(input logic fr, input logic [15:0] p, input logic l, input logic s,
                      input logic [15:0] da, input logic [31:0] sd,
                      input logic wi, input logic wd, input logic re, input logic we,
                      input logic [13:0] a, input logic [31:0] ins, input logic [31:0] ldd);
      vec_t v;
      v = '{fr, p, l, s, da, sd, wi, wd, re, we, a, ins, ldd};
      vq.push_back(v);
   endtask

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic fr, input logic [15:0] p, input logic l, input logic s,
                        input logic [15:0] da, input logic [31:0] sd);
      fetch_req = fr; pc = p; ld = l; st = s; data_addr = da; store_data = sd;
   endtask

   task automatic preload(input logic [13:0] a, input logic [31:0] d);
      bk_addr = a; bk_dat = d; bk_we = 1'b1;
      @(posedge clk); #1;
      bk_we = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk); resetn = 1'b0; drive(0, 0, 0, 0, 0, 0);
      @(negedge clk); resetn = 1'b1;
   endtask

   localparam logic [31:0] D = 32'hDEADBEEF, S = 32'h12345678, A = 32'hA5A50001, C = 32'hCAFEF00D;

   initial begin
      resetn = 1'b0; bk_we = 1'b0; bk_addr = '0; bk_dat = '0;
      drive(0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      preload(14'h0004, D);
      preload(14'h0008, C);
      preload(14'h1000, A);
      preload(14'h1003, 32'h77777777);

      // Reset state, with a fetch presented while reset is low
      @(negedge clk); drive(1, 16'h0010, 0, 0, 0, 0); #2;
      chk("reset_state", {wait_instr, wait_data, instr_segv, data_segv, mem_re, mem_we, mem_addr, mem_wdata, instruction, load_data},
          {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 14'h0, 32'h0, 32'h0, 32'h0});
      @(negedge clk); resetn = 1'b1; drive(0, 0, 0, 0, 0, 0); #2;
      chk("reset_req_ignored", {wait_instr, mem_re}, {1'b0, 1'b0});

      //   fr  pc       ld st da       sd            wi wd re we addr     ins ldd
      add(1, 16'h0010, 0, 0, 16'h0,    32'h0,        1, 0, 0, 0, 14'h000, 0, 0);
      add(1, 16'h0010, 0, 0, 16'h0,    32'h0,        1, 0, 1, 0, 14'h004, 0, 0);
      add(1, 16'h0010, 0, 0, 16'h0,    32'h0,        1, 0, 0, 0, 14'h004, 0, 0);
      add(1, 16'h0010, 0, 0, 16'h0,    32'h0,        0, 0, 0, 0, 14'h004, 0, 0);
      add(0, 16'h0000, 0, 0, 16'h0,    32'h0,        0, 0, 0, 0, 14'h004, D, 0);
      add(0, 16'h0000, 0, 1, 16'h4008, S,            0, 1, 0, 0, 14'h004, D, 0);
      add(0, 16'h0000, 0, 1, 16'h4008, S,            0, 0, 0, 1, 14'h1002, D, 0);
      add(0, 16'h0000, 1, 0, 16'h4008, 32'h0,        0, 1, 0, 0, 14'h1002, D, 0);
      add(0, 16'h0000, 1, 0, 16'h4008, 32'h0,        0, 1, 1, 0, 14'h1002, D, 0);
      add(0, 16'h0000, 1, 0, 16'h4008, 32'h0,        0, 1, 0, 0, 14'h1002, D, 0);
      add(0, 16'h0000, 1, 0, 16'h4008, 32'h0,        0, 0, 0, 0, 14'h1002, D, 0);
      add(0, 16'h0000, 0, 0, 16'h0,    32'h0,        0, 0, 0, 0, 14'h1002, D, S);
      add(1, 16'h0020, 1, 0, 16'h4000, 32'h0,        1, 1, 0, 0, 14'h1002, D, S);
      add(1, 16'h0020, 1, 0, 16'h4000, 32'h0,        1, 1, 1, 0, 14'h1000, D, S);
      add(1, 16'h0020, 1, 0, 16'h4000, 32'h0,        1, 1, 0, 0, 14'h1000, D, S);
      add(1, 16'h0020, 1, 0, 16'h4000, 32'h0,        1, 0, 0, 0, 14'h1000, D, S);
      add(1, 16'h0020, 0, 0, 16'h0,    32'h0,        1, 0, 0, 0, 14'h1000, D, A);
      add(1, 16'h0020, 0, 0, 16'h0,    32'h0,        1, 0, 1, 0, 14'h008, D, A);
      add(1, 16'h0020, 0, 0, 16'h0,    32'h0,        1, 0, 0, 0, 14'h008, D, A);
      add(1, 16'h0020, 0, 0, 16'h0,    32'h0,        0, 0, 0, 0, 14'h008, D, A);
      add(0, 16'h0000, 0, 0, 16'h0,    32'h0,        0, 0, 0, 0, 14'h008, C, A);
      add(0, 16'h0000, 0, 1, 16'h4010, 32'h11111111, 0, 1, 0, 0, 14'h008, C, A);
      add(0, 16'h0000, 0, 1, 16'h4010, 32'h11111111, 0, 0, 0, 1, 14'h1004, C, A);
      add(0, 16'h0000, 0, 1, 16'h4014, 32'h22222222, 0, 1, 0, 0, 14'h1004, C, A);
      add(0, 16'h0000, 0, 1, 16'h4014, 32'h22222222, 0, 0, 0, 1, 14'h1005, C, A);
      add(0, 16'h0000, 1, 0, 16'h4010, 32'h0,        0, 1, 0, 0, 14'h1005, C, A);
      add(0, 16'h0000, 1, 0, 16'h4010, 32'h0,        0, 1, 1, 0, 14'h1004, C, A);
      add(0, 16'h0000, 1, 0, 16'h4010, 32'h0,        0, 1, 0, 0, 14'h1004, C, A);
      add(0, 16'h0000, 1, 0, 16'h4010, 32'h0,        0, 0, 0, 0, 14'h1004, C, A);
      add(0, 16'h0000, 0, 0, 16'h0,    32'h0,        0, 0, 0, 0, 14'h1004, C, 32'h11111111);

      foreach (vq[i]) begin
         @(negedge clk);
         drive(vq[i].fr, vq[i].pc, vq[i].ld, vq[i].st, vq[i].da, vq[i].sd);
         #2;
         chk($sformatf("vec%0d", i),
             {instr_segv, data_segv, wait_instr, wait_data, mem_re, mem_we, mem_addr, instruction, load_data},
             {1'b0, 1'b0, vq[i].wi, vq[i].wd, vq[i].re, vq[i].we, vq[i].addr, vq[i].ins, vq[i].ldd});
      end

      // Reset in the middle of a load: access aborted, late data discarded
      do_reset();
      @(negedge clk); drive(0, 0, 1, 0, 16'h400C, 0); #2;
      @(negedge clk); #2;
      chk("midload_re", {mem_re, mem_addr}, {1'b1, 14'h1003});
      @(negedge clk); resetn = 1'b0; drive(0, 0, 0, 0, 0, 0); #2;
      chk("midload_rst", {wait_data, mem_re, mem_we}, {1'b0, 1'b0, 1'b0});
      @(negedge clk); resetn = 1'b1; #2;
      chk("midload_after", {mem_re, wait_data, load_data}, {1'b0, 1'b0, 32'h0});
      @(negedge clk); #2;
      chk("midload_discard", load_data, 32'h0);
      @(negedge clk); drive(0, 0, 0, 1, 16'h4018, 32'h33); #2;
      chk("midload_idle_st", {wait_data, mem_we}, {1'b1, 1'b0});
      @(negedge clk); #2;
      chk("midload_idle_we", {wait_data, mem_we, mem_addr, mem_wdata}, {1'b0, 1'b1, 14'h1006, 32'h33});

      // Load outside the data window
      do_reset();
      @(negedge clk); drive(0, 0, 1, 0, 16'h0100, 0); #2;
      chk("oob_accept", {wait_data, data_segv}, {1'b1, 1'b0});
      @(negedge clk); drive(0, 0, 0, 0, 0, 0); #2;
      chk("oob_segv", {data_segv, instr_segv, wait_instr, wait_data, mem_re, mem_we}, 6'b101100);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk); drive(1, 16'h0010, 0, 0, 0, 0); #2;
         chk($sformatf("fault_hold%0d", k), {data_segv, instr_segv, wait_instr, wait_data, mem_re, mem_we}, 6'b101100);
      end
      @(negedge clk); resetn = 1'b0; drive(0, 0, 0, 0, 0, 0); #2;
      chk("fault_rst_waits", {wait_instr, wait_data}, 2'b00);
      @(negedge clk); resetn = 1'b1; #2;
      chk("fault_cleared", {data_segv, instr_segv, wait_instr, wait_data}, 4'b0000);

      // ld and st together
      do_reset();
      @(negedge clk); drive(0, 0, 1, 1, 16'h4000, 32'h55); #2;
      @(negedge clk); drive(0, 0, 0, 0, 0, 0); #2;
      chk("ldst_segv", {data_segv, instr_segv, mem_re, mem_we, wait_data}, 5'b10001);

      // Misaligned fetch
      do_reset();
      @(negedge clk); drive(1, 16'h0012, 0, 0, 0, 0); #2;
      chk("mis_accept", wait_instr, 1'b1);
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
      @(negedge clk); drive(0, 0, 0, 0, 0, 0); #2;
      chk("mis_segv", {instr_segv, data_segv, mem_re, wait_instr}, 4'b1001);
`else
      @(negedge clk); #2;
      chk("mis_re", {instr_segv, mem_re, mem_addr}, {1'b0, 1'b1, 14'h004});
      @(negedge clk); #2;
      @(negedge clk); #2;
      chk("mis_done", wait_instr, 1'b0);
      @(negedge clk); drive(0, 0, 0, 0, 0, 0); #2;
      chk("mis_word", {instr_segv, instruction}, {1'b0, D});
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
